// File: rtl/rx_frame_dispatcher.sv
// rtl/rx_frame_dispatcher.sv - drains committed Rx ring frames onto an AXI4-Stream master
//
// Reads the two-word header at each ring frame base, streams the payload words
// with byte keeps and per-packet tuser, then releases ring space by advancing
// commited_rd_address. Malformed headers drop all pending frames.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   commited_wr_address [AW]  next free header slot from the Rx MAC side
//   commited_rd_address [AW]  oldest unconsumed frame base (ring release pointer)
//   rd_addr [AW] / rd_data    buffer read port, data valid 1 cycle after address
//   m_axis_*                  AXI4-Stream master (tdata/tkeep/tuser/tvalid/tlast/tready)
//   err_count [32]            count of malformed headers
// Optional macro RX_DISPATCH_STATS_EN adds frame_count[32] and byte_count[48].
module rx_frame_dispatcher #(
    parameter int AW      = 10,
    parameter int MAX_LEN = 9600
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] commited_wr_address,
    output logic [AW-1:0] commited_rd_address,
    output logic [AW-1:0] rd_addr,
    input  logic [63:0]   rd_data,
    output logic [63:0]   m_axis_tdata,
    output logic [7:0]    m_axis_tkeep,
    output logic [95:0]   m_axis_tuser,
    output logic          m_axis_tvalid,
    output logic          m_axis_tlast,
    input  logic          m_axis_tready,
`ifdef RX_DISPATCH_STATS_EN
    output logic [31:0]   frame_count,
    output logic [47:0]   byte_count,
`endif
    output logic [31:0]   err_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_TS, S_DATA, S_COMMIT, S_ERR
    } state_t;

    localparam int          CW        = 14;
    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

    state_t        state_q, state_d;
    logic [AW-1:0] crd_q, crd_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    src_q, src_d, des_q, des_d;
    logic [CW-1:0] reads_left_q, reads_left_d;
    logic [CW-1:0] loads_left_q, loads_left_d;
    logic          inflight_q, inflight_d;
    logic [63:0]   fifo_q [2];
    logic [63:0]   fifo_d [2];
    logic          fifo_rp_q, fifo_rp_d, fifo_wp_q, fifo_wp_d;
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [63:0]   tdata_q, tdata_d;
    logic [7:0]    tkeep_q, tkeep_d;
    logic [95:0]   tuser_q, tuser_d;
    logic          tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [31:0]   err_q, err_d;
`ifdef RX_DISPATCH_STATS_EN
    logic [31:0]   frames_q, frames_d;
    logic [47:0]   bytes_q, bytes_d;
`endif

    logic [15:0]   hdr_len;
    logic          hdr_bad;
    logic [16:0]   len_plus7;
    logic [CW-1:0] n_words;
    logic [7:0]    last_keep;
    logic          out_ready, rd_issue, push, pop, load;
    logic [63:0]   load_data;

    assign hdr_len   = rd_data[47:32];
    assign hdr_bad   = (hdr_len == 16'd0) || ({1'b0, hdr_len} > MAX_LEN_W);
    assign len_plus7 = {1'b0, len_q} + 17'd7;
    assign n_words   = len_plus7[16:3];
    assign last_keep = (len_q[2:0] == 3'd0) ? 8'hFF : ((8'h01 << len_q[2:0]) - 8'h01);
    assign out_ready = !tvalid_q || m_axis_tready;

    always_comb begin
        state_d      = state_q;
        crd_d        = crd_q;
        raddr_d      = raddr_q;
        len_d        = len_q;
        src_d        = src_q;
        des_d        = des_q;
        reads_left_d = reads_left_q;
        loads_left_d = loads_left_q;
        tuser_d      = tuser_q;
        err_d        = err_q;
        rd_issue     = 1'b0;
`ifdef RX_DISPATCH_STATS_EN
        frames_d     = frames_q;
        bytes_d      = bytes_q;
`endif

        // raddr_q rests on the frame base in IDLE, so the header read is
        // already on the port in the cycle a frame becomes visible.
        unique case (state_q)
            S_IDLE: begin
                if (crd_q != commited_wr_address) begin
                    raddr_d = raddr_q + AW'(1);
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                len_d = hdr_len;
                des_d = rd_data[23:16];
                src_d = rd_data[7:0];
                if (hdr_bad) begin
                    state_d = S_ERR;
                end else begin
                    raddr_d = raddr_q + AW'(1);
                    state_d = S_TS;
                end
            end
            S_TS: begin
                tuser_d      = {rd_data, des_q, src_q, len_q};
                rd_issue     = 1'b1;
                raddr_d      = raddr_q + AW'(1);
                reads_left_d = n_words - CW'(1);
                loads_left_d = n_words;
                state_d      = S_DATA;
            end
            S_DATA: begin
                // Output register plus 2-entry FIFO: a read is only issued if
                // the FIFO is guaranteed room when its data comes back.
                if (reads_left_q != '0 &&
                    ({1'b0, fifo_cnt_q} + {2'b0, inflight_q}) < 3'd2) begin
                    rd_issue     = 1'b1;
                    raddr_d      = raddr_q + AW'(1);
                    reads_left_d = reads_left_q - CW'(1);
                end
                if (tvalid_q && m_axis_tready && tlast_q)
                    state_d = S_COMMIT;
            end
            S_COMMIT: begin
                // After the last read raddr_q already points at B+2+N.
                crd_d   = raddr_q;
                state_d = S_IDLE;
`ifdef RX_DISPATCH_STATS_EN
                frames_d = frames_q + 32'd1;
                bytes_d  = bytes_q + {32'd0, len_q};
`endif
            end
            S_ERR: begin
                crd_d   = commited_wr_address;
                raddr_d = commited_wr_address;
                err_d   = err_q + 32'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Output register fill: FIFO head first, else bypass the returning read.
        push      = 1'b0;
        pop       = 1'b0;
        load      = 1'b0;
        load_data = fifo_q[fifo_rp_q];
        if (out_ready && fifo_cnt_q != 2'd0) begin
            load = 1'b1;
            pop  = 1'b1;
            push = inflight_q;
        end else if (out_ready && inflight_q) begin
            load      = 1'b1;
            load_data = rd_data;
        end else begin
            push = inflight_q;
        end

        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        if (load) begin
            tdata_d      = load_data;
            tvalid_d     = 1'b1;
            tlast_d      = (loads_left_q == CW'(1));
            tkeep_d      = (loads_left_q == CW'(1)) ? last_keep : 8'hFF;
            loads_left_d = loads_left_q - CW'(1);
        end else if (out_ready) begin
            tvalid_d = 1'b0;
        end

        fifo_d[0]  = fifo_q[0];
        fifo_d[1]  = fifo_q[1];
        fifo_wp_d  = fifo_wp_q;
        fifo_rp_d  = fifo_rp_q;
        if (push) begin
            fifo_d[fifo_wp_q] = rd_data;
            fifo_wp_d         = ~fifo_wp_q;
        end
        if (pop)
            fifo_rp_d = ~fifo_rp_q;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        inflight_d = rd_issue;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            crd_q        <= '0;
            raddr_q      <= '0;
            len_q        <= '0;
            src_q        <= '0;
            des_q        <= '0;
            reads_left_q <= '0;
            loads_left_q <= '0;
            inflight_q   <= 1'b0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            fifo_rp_q    <= 1'b0;
            fifo_wp_q    <= 1'b0;
            fifo_cnt_q   <= '0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tuser_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            err_q        <= '0;
`ifdef RX_DISPATCH_STATS_EN
            frames_q     <= '0;
            bytes_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            crd_q        <= crd_d;
            raddr_q      <= raddr_d;
            len_q        <= len_d;
            src_q        <= src_d;
            des_q        <= des_d;
            reads_left_q <= reads_left_d;
            loads_left_q <= loads_left_d;
            inflight_q   <= inflight_d;
            fifo_q[0]    <= fifo_d[0];
            fifo_q[1]    <= fifo_d[1];
            fifo_rp_q    <= fifo_rp_d;
            fifo_wp_q    <= fifo_wp_d;
            fifo_cnt_q   <= fifo_cnt_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tuser_q      <= tuser_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            err_q        <= err_d;
`ifdef RX_DISPATCH_STATS_EN
            frames_q     <= frames_d;
            bytes_q      <= bytes_d;
`endif
        end
    end

    assign commited_rd_address = crd_q;
    assign rd_addr             = raddr_q;
    assign m_axis_tdata        = tdata_q;
    assign m_axis_tkeep        = tkeep_q;
    assign m_axis_tuser        = tuser_q;
    assign m_axis_tvalid       = tvalid_q;
    assign m_axis_tlast        = tlast_q;
    assign err_count           = err_q;
`ifdef RX_DISPATCH_STATS_EN
    assign frame_count         = frames_q;
    assign byte_count          = bytes_q;
`endif

endmodule

// File: tb/tb_rx_frame_dispatcher.sv
// tb/tb_rx_frame_dispatcher.sv - scoreboard bench for rx_frame_dispatcher
module tb_rx_frame_dispatcher;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [95:0] user;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic [9:0]  wr = '0;
    logic [9:0]  crd, rd_addr;
    logic [63:0] rd_data = '0;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic [95:0] tuser;
    logic        tvalid, tlast;
    logic        tready = 1'b1;
    logic [31:0] err_count;

    logic [3:0]  wr4 = '0;
    logic [3:0]  crd4, rd_addr4;
    logic [63:0] rd_data4 = '0;
    logic [63:0] tdata4;
    logic [7:0]  tkeep4;
    logic [95:0] tuser4;
    logic        tvalid4, tlast4;
    logic        tready4 = 1'b1;
    logic [31:0] err_count4;

    logic [63:0] mem  [0:1023];
    logic [63:0] mem4 [0:15];

    rx_frame_dispatcher #(.AW(10), .MAX_LEN(9600)) dut (
        .clk(clk), .reset_n(reset_n),
        .commited_wr_address(wr), .commited_rd_address(crd),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tuser(tuser),
        .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tready(tready),
        .err_count(err_count)
    );

    rx_frame_dispatcher #(.AW(4), .MAX_LEN(9600)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .commited_wr_address(wr4), .commited_rd_address(crd4),
        .rd_addr(rd_addr4), .rd_data(rd_data4),
        .m_axis_tdata(tdata4), .m_axis_tkeep(tkeep4), .m_axis_tuser(tuser4),
        .m_axis_tvalid(tvalid4), .m_axis_tlast(tlast4), .m_axis_tready(tready4),
        .err_count(err_count4)
    );

    always @(posedge clk) begin
        rd_data  <= mem[rd_addr];
        rd_data4 <= mem4[rd_addr4];
    end

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    beats = 0;
    bit    rnd_ready = 0;
    bit    stalled = 0;
    beat_t held;

    always @(negedge clk) begin
        beat_t got, e;
        got = {tdata, tkeep, tlast, tuser};
        if (!reset_n) begin
            stalled = 0;
        end else if (tvalid) begin
            if (stalled) begin
                n_vec++;
                if (got !== held) begin
                    n_err++;
                    $display("FAIL axi_hold got=%h required=%h", got, held);
                end
            end
            if (tready) begin
                n_vec++;
                beats++;
                stalled = 0;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat got=%h required=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL beat%0d got=%h required=%h", beats, got, e);
                    end
                end
            end else begin
                stalled = 1;
                held    = got;
            end
        end else if (stalled) begin
            n_vec++;
            n_err++;
            stalled = 0;
            $display("FAIL valid_dropped got=0 required=1");
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_ready) tready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [7:0] exp_keep(input int len, input bit last);
        if (!last || (len % 8) == 0) return 8'hFF;
        return 8'((1 << (len % 8)) - 1);
    endfunction

    task automatic write_frame(input int base, input int len, input logic [7:0] src,
                               input logic [7:0] des, output int next);
        int          n;
        logic [63:0] ts, d;
        beat_t       b;
        n  = (len + 7) >> 3;
        ts = {$urandom, $urandom};
        mem[base % 1024]       = {16'h0, 16'(len), 8'h0, des, 8'h0, src};
        mem[(base + 1) % 1024] = ts;
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom};
            mem[(base + 2 + i) % 1024] = d;
            b.data = d;
            b.last = (i == n - 1);
            b.keep = exp_keep(len, i == n - 1);
            b.user = {ts, des, src, 16'(len)};
            exp_q.push_back(b);
        end
        next = (base + 2 + n) % 1024;
    endtask

    task automatic wait_done(input logic [9:0] target, input int budget, input string name);
        int c = 0;
        while (!(crd == target && exp_q.size() == 0) && c < budget) begin
            step();
            c++;
        end
        n_vec++;
        if (!(crd == target && exp_q.size() == 0)) begin
            n_err++;
            $display("FAIL %s_timeout crd=%0d required=%0d pending=%0d", name, crd, target, exp_q.size());
        end
        n_vec++;
        if (crd !== target) begin
            n_err++;
            $display("FAIL %s_rd_ptr got=%0d required=%0d", name, crd, target);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_vec++;
        if ({crd, rd_addr} !== 20'h0) begin
            n_err++;
            $display("FAIL %s_ptrs got=%h required=0", name, {crd, rd_addr});
        end
        n_vec++;
        if ({tvalid, tlast, tkeep} !== 10'h0) begin
            n_err++;
            $display("FAIL %s_qual got=%h required=0", name, {tvalid, tlast, tkeep});
        end
        n_vec++;
        if ({tdata, tuser} !== 160'h0) begin
            n_err++;
            $display("FAIL %s_data got=%h required=0", name, {tdata, tuser});
        end
        n_vec++;
        if (err_count !== 32'h0) begin
            n_err++;
            $display("FAIL %s_err_count got=%0d required=0", name, err_count);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        n_vec++;
        if ({crd4, rd_addr4, tvalid4} !== 9'h0) begin
            n_err++;
            $display("FAIL reset_aw4 got=%h required=0", {crd4, rd_addr4, tvalid4});
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int nb, b0;
        b0 = beats;
        write_frame(0, 64, 8'h11, 8'h22, nb);
        @(posedge clk);
        #1;
        wr = 10'(nb);
        step(); step(); step();
        n_vec++;
        if (tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL first_valid_c3 got=%b required=0", tvalid);
        end
        step();
        n_vec++;
        if (tvalid !== 1'b1) begin
            n_err++;
            $display("FAIL first_valid_c4 got=%b required=1", tvalid);
        end
        wait_done(10'd10, 100, "single");
        n_vec++;
        if (beats - b0 != 8) begin
            n_err++;
            $display("FAIL single_beats got=%0d required=8", beats - b0);
        end
    endtask

    task automatic test_len_boundaries();
        int nb, b0;
        int lens[3] = '{61, 1, 8};
        int base = 10;
        b0 = beats;
        foreach (lens[k]) begin
            write_frame(base, lens[k], 8'(k + 3), 8'(k + 7), nb);
            wr = 10'(nb);
            wait_done(10'(nb), 100, "len");
            base = nb;
        end
        n_vec++;
        if (beats - b0 != 8 + 1 + 1) begin
            n_err++;
            $display("FAIL len_beats got=%0d required=10", beats - b0);
        end
    endtask

    task automatic test_back_to_back();
        int nb, b0;
        int base;
        b0 = beats;
        base = int'(crd);
        for (int f = 0; f < 3; f++) begin
            write_frame(base, 1500, 8'(f), 8'(f + 100), nb);
            base = nb;
        end
        rnd_ready = 1;
        wr = 10'(base);
        wait_done(10'(base), 3000, "b2b");
        rnd_ready = 0;
        tready = 1'b1;
        n_vec++;
        if (beats - b0 != 3 * 188) begin
            n_err++;
            $display("FAIL b2b_beats got=%0d required=%0d", beats - b0, 3 * 188);
        end
    endtask

    task automatic test_bad_header();
        int b0, base;
        int lens[2] = '{0, 9601};
        b0 = beats;
        foreach (lens[k]) begin
            base = int'(crd);
            mem[base] = {16'h0, 16'(lens[k]), 8'h0, 8'h5A, 8'h0, 8'hA5};
            wr = 10'(base + 20);
            wait_done(10'(base + 20), 20, "bad");
            n_vec++;
            if (err_count !== 32'(k + 1)) begin
                n_err++;
                $display("FAIL bad_err_count got=%0d required=%0d", err_count, k + 1);
            end
        end
        n_vec++;
        if (beats != b0) begin
            n_err++;
            $display("FAIL bad_no_stream got=%0d required=0", beats - b0);
        end
    endtask

    task automatic test_reset_midframe();
        int nb, b0, c;
        reset_n = 1'b0;
        wr = '0;
        step();
        exp_q.delete();
        write_frame(0, 64, 8'h33, 8'h44, nb);
        reset_n = 1'b1;
        step();
        b0 = beats;
        wr = 10'd10;
        c = 0;
        while (beats - b0 < 3 && c < 50) begin
            step();
            c++;
        end
        n_vec++;
        if (beats - b0 != 3) begin
            n_err++;
            $display("FAIL mid_beat3 got=%0d required=3", beats - b0);
        end
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        write_frame(0, 64, 8'h55, 8'h66, nb);
        step(); step();
        reset_n = 1'b1;
        wait_done(10'd10, 100, "mid_restart");
        n_vec++;
        if (beats - b0 != 3 + 8) begin
            n_err++;
            $display("FAIL mid_beats got=%0d required=11", beats - b0);
        end
    endtask

    task automatic test_wrap();
        beat_t       q4[$];
        beat_t       e, b;
        logic [63:0] ts, d;
        int          seq[6];
        int          na, last_a, base, len, n, target;
        na = 0;
        last_a = -1;
        for (int f = 0; f < 2; f++) begin
            base   = (f == 0) ? 0 : 14;
            len    = (f == 0) ? 96 : 24;
            n      = (len + 7) >> 3;
            target = (base + 2 + n) % 16;
            ts     = {$urandom, $urandom};
            mem4[base % 16]       = {16'h0, 16'(len), 8'h0, 8'h09, 8'h0, 8'h08};
            mem4[(base + 1) % 16] = ts;
            for (int i = 0; i < n; i++) begin
                d = {$urandom, $urandom};
                mem4[(base + 2 + i) % 16] = d;
                b.data = d;
                b.last = (i == n - 1);
                b.keep = 8'hFF;
                b.user = {ts, 8'h09, 8'h08, 16'(len)};
                q4.push_back(b);
            end
            @(posedge clk);
            #1;
            wr4 = 4'(target);
            for (int c = 0; c < 100 && !(crd4 == 4'(target) && q4.size() == 0); c++) begin
                @(negedge clk);
                if (f == 1 && int'(rd_addr4) != last_a) begin
                    if (na < 6) seq[na] = int'(rd_addr4);
                    na++;
                    last_a = int'(rd_addr4);
                end
                if (tvalid4) begin
                    n_vec++;
                    if (q4.size() == 0) begin
                        n_err++;
                        $display("FAIL wrap_unexpected got=%h required=none", tdata4);
                    end else begin
                        e = q4.pop_front();
                        if ({tdata4, tkeep4, tlast4, tuser4} !== e) begin
                            n_err++;
                            $display("FAIL wrap_beat got=%h required=%h", {tdata4, tkeep4, tlast4, tuser4}, e);
                        end
                    end
                end
                @(posedge clk);
                #1;
            end
            n_vec++;
            if (crd4 !== 4'(target) || q4.size() != 0) begin
                n_err++;
                $display("FAIL wrap_ptr got=%0d required=%0d pending=%0d", crd4, target, q4.size());
            end
        end
        n_vec++;
        if (na < 6 || seq[0] != 14 || seq[1] != 15 || seq[2] != 0 ||
            seq[3] != 1 || seq[4] != 2 || seq[5] != 3) begin
            n_err++;
            $display("FAIL wrap_reads got=%0d,%0d,%0d,%0d,%0d,%0d required=14,15,0,1,2,3",
                     seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) mem4[i] = '0;
        test_reset();
        test_single();
        test_len_boundaries();
        test_back_to_back();
        test_bad_header();
        test_wrap();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
